// File: rtl/dsp48_pkg.sv
// Shared types, constants and helpers for the DSP48A1 pipeline-stage monitors.
package dsp48_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } mon_state_e;

  localparam string RST_SYNC  = "SYNC";
  localparam string RST_ASYNC = "ASYNC";

  // Counters up to 32 bits wide; the result sticks at 2**width-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/reg_mux_model.sv
// Cycle-accurate reference of one REG_MUX stage: the value the observed
// stage should present on its output, plus a flag that the model is primed.
module reg_mux_model
  import dsp48_pkg::*;
#(
  parameter string RSTTYPE = RST_SYNC,
  parameter int    Xy_REG  = 0,
  parameter int    WIDTH   = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             dut_rst,
  input  logic             clk_en,
  output logic [WIDTH-1:0] exp,
  output logic             model_valid
);

  localparam bit IS_ASYNC = (RSTTYPE == RST_ASYNC);

  logic [WIDTH-1:0] exp_q;
  logic             valid_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (dut_rst)     exp_q <= '0;
      else if (clk_en) exp_q <= d;
      if (dut_rst || clk_en) valid_q <= 1'b1;
    end
  end

  // NOTE: assigning a default at the top of every always_comb guarantees
  // each path drives the output, so no latch is inferred.
  always_comb begin
    exp = exp_q;
    if (Xy_REG == 0)               exp = d;
    else if (IS_ASYNC && dut_rst)  exp = '0;
  end

  assign model_valid = valid_q;

endmodule

// File: rtl/reg_mux_monitor.sv
// Observer for one REG_MUX stage: compares the tapped output against a
// reference model every cycle, counts checks/errors and captures the first failure.
module reg_mux_monitor
  import dsp48_pkg::*;
#(
  parameter string RSTTYPE     = RST_SYNC,
  parameter int    Xy_REG      = 0,
  parameter int    WIDTH       = 18,
  parameter int    CNT_W       = 16,   // at most 32
  parameter int    STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             dut_rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] dut_out,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic [CNT_W-1:0] first_cyc,
  output logic [1:0]       state
);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_cyc_q, first_cyc_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_act_q, first_act_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;

  logic [WIDTH-1:0] exp_val;
  logic             model_valid;
  logic             compare;
  logic             mismatch;

  reg_mux_model #(
    .RSTTYPE (RSTTYPE),
    .Xy_REG  (Xy_REG),
    .WIDTH   (WIDTH)
  ) u_model (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .dut_rst     (dut_rst),
    .clk_en      (clk_en),
    .exp         (exp_val),
    .model_valid (model_valid)
  );

  assign compare  = (state_q == ST_RUN);
  assign mismatch = compare && (dut_out != exp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!chk_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ((Xy_REG == 0) || model_valid) ? ST_RUN : ST_WAIT;
        ST_WAIT: if (model_valid) state_d = ST_RUN;
        // A clear in the same cycle discards the compare, so it cannot halt.
        ST_RUN:  if (mismatch && (STOP_ON_ERR != 0) && !clr) state_d = ST_HALT;
        ST_HALT: if (clr) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    chk_cnt_d    = chk_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_cyc_d  = first_cyc_q;
    first_exp_d  = first_exp_q;
    first_act_d  = first_act_q;
    err_sticky_d = err_sticky_q;
    err_pulse_d  = 1'b0;
    if (clr) begin
      chk_cnt_d    = '0;
      err_cnt_d    = '0;
      first_cyc_d  = '0;
      first_exp_d  = '0;
      first_act_d  = '0;
      err_sticky_d = 1'b0;
    end else if (compare) begin
      chk_cnt_d = CNT_W'(sat_inc(32'(chk_cnt_q), CNT_W));
      if (mismatch) begin
        err_pulse_d  = 1'b1;
        err_cnt_d    = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
        err_sticky_d = 1'b1;
        if (!err_sticky_q) begin
          first_exp_d = exp_val;
          first_act_d = dut_out;
          first_cyc_d = chk_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_cyc_q  <= '0;
      first_exp_q  <= '0;
      first_act_q  <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      chk_cnt_q    <= chk_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_cyc_q  <= first_cyc_d;
      first_exp_q  <= first_exp_d;
      first_act_q  <= first_act_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign chk_cnt    = chk_cnt_q;
  assign first_exp  = first_exp_q;
  assign first_act  = first_act_q;
  assign first_cyc  = first_cyc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_reg_mux_monitor.sv
// Three monitors (registered SYNC, registered ASYNC with halt, bypass with
// 4-bit counters) watch bench-side REG_MUX stages with injectable faults.
module tb_reg_mux_monitor;

  localparam int W = 18;
  localparam int S_IDLE = 0, S_WAIT = 1, S_RUN = 2, S_HALT = 3;

  localparam int XREG  [3] = '{1, 1, 0};
  localparam int ASYNC [3] = '{0, 1, 0};
  localparam int STOP  [3] = '{0, 1, 0};
  localparam int CNTW  [3] = '{16, 16, 4};

  logic         clk, rst_n, chk_en, clr, dut_rst, clk_en;
  logic [W-1:0] d;
  logic [W-1:0] dout [3];

  logic         pulse0, sticky0, pulse1, sticky1, pulse2, sticky2;
  logic [15:0]  err0, chk0, fcyc0, err1, chk1, fcyc1;
  logic [3:0]   err2, chk2, fcyc2;
  logic [W-1:0] fexp0, fact0, fexp1, fact1, fexp2, fact2;
  logic [1:0]   st0, st1, st2;

  reg_mux_monitor #(.RSTTYPE("SYNC"), .Xy_REG(1), .WIDTH(W), .CNT_W(16), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .d(d), .dut_rst(dut_rst),
    .clk_en(clk_en), .dut_out(dout[0]), .err_pulse(pulse0), .err_sticky(sticky0),
    .err_cnt(err0), .chk_cnt(chk0), .first_exp(fexp0), .first_act(fact0),
    .first_cyc(fcyc0), .state(st0));

  reg_mux_monitor #(.RSTTYPE("ASYNC"), .Xy_REG(1), .WIDTH(W), .CNT_W(16), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .d(d), .dut_rst(dut_rst),
    .clk_en(clk_en), .dut_out(dout[1]), .err_pulse(pulse1), .err_sticky(sticky1),
    .err_cnt(err1), .chk_cnt(chk1), .first_exp(fexp1), .first_act(fact1),
    .first_cyc(fcyc1), .state(st1));

  reg_mux_monitor #(.RSTTYPE("SYNC"), .Xy_REG(0), .WIDTH(W), .CNT_W(4), .STOP_ON_ERR(0)) u2 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .d(d), .dut_rst(dut_rst),
    .clk_en(clk_en), .dut_out(dout[2]), .err_pulse(pulse2), .err_sticky(sticky2),
    .err_cnt(err2), .chk_cnt(chk2), .first_exp(fexp2), .first_act(fact2),
    .first_cyc(fcyc2), .state(st2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference monitor state, one entry per instance.
  typedef struct {
    int st; int chk; int err; bit sticky; bit pulse;
    int fexp; int fact; int fcyc; int last; bit primed;
  } mdl_t;
  mdl_t m [3];

  // Bench-side observed REG_MUX stages and fault controls.
  int stage [3];
  bit stale [3];      // async stage that ignores its reset combinationally
  bit force_en [3];
  int force_val [3];

  function automatic int stage_out(input int i);
    if (force_en[i])                          return force_val[i];
    if (XREG[i] == 0)                         return int'(d);
    if (ASYNC[i] != 0 && dut_rst && !stale[i]) return 0;
    return stage[i];
  endfunction

  task automatic model_step(input int i);
    int  e, mx, nst;
    bit  run, mis;
    mx = (1 << CNTW[i]) - 1;
    if (XREG[i] == 0)                  e = int'(d);
    else if (ASYNC[i] != 0 && dut_rst) e = 0;
    else                               e = m[i].last;
    run = (m[i].st == S_RUN);
    mis = run && (int'(dout[i]) != e);

    nst = m[i].st;
    if (!chk_en)                                             nst = S_IDLE;
    else if (m[i].st == S_IDLE)                              nst = (XREG[i] == 0 || m[i].primed) ? S_RUN : S_WAIT;
    else if (m[i].st == S_WAIT && m[i].primed)               nst = S_RUN;
    else if (m[i].st == S_RUN && mis && STOP[i] != 0 && !clr) nst = S_HALT;
    else if (m[i].st == S_HALT && clr)                       nst = S_RUN;

    m[i].pulse = 1'b0;
    if (clr) begin
      m[i].chk = 0; m[i].err = 0; m[i].sticky = 1'b0;
      m[i].fexp = 0; m[i].fact = 0; m[i].fcyc = 0;
    end else if (run) begin
      if (mis && !m[i].sticky) begin
        m[i].fexp = e; m[i].fact = int'(dout[i]); m[i].fcyc = m[i].chk;
      end
      m[i].chk = (m[i].chk < mx) ? m[i].chk + 1 : mx;
      if (mis) begin
        m[i].err    = (m[i].err < mx) ? m[i].err + 1 : mx;
        m[i].sticky = 1'b1;
        m[i].pulse  = 1'b1;
      end
    end
    m[i].st = nst;

    if (dut_rst)     m[i].last = 0;
    else if (clk_en) m[i].last = int'(d);
    if (dut_rst || clk_en) m[i].primed = 1'b1;
  endtask

  task automatic check_inst(input int i, input logic [31:0] st, pl, sk, ec, cc, fe, fa, fc);
    check($sformatf("u%0d.state", i),      st, 32'(m[i].st));
    check($sformatf("u%0d.err_pulse", i),  pl, 32'(m[i].pulse));
    check($sformatf("u%0d.err_sticky", i), sk, 32'(m[i].sticky));
    check($sformatf("u%0d.err_cnt", i),    ec, 32'(m[i].err));
    check($sformatf("u%0d.chk_cnt", i),    cc, 32'(m[i].chk));
    check($sformatf("u%0d.first_exp", i),  fe, 32'(m[i].fexp));
    check($sformatf("u%0d.first_act", i),  fa, 32'(m[i].fact));
    check($sformatf("u%0d.first_cyc", i),  fc, 32'(m[i].fcyc));
  endtask

  task automatic check_all();
    check_inst(0, 32'(st0), 32'(pulse0), 32'(sticky0), 32'(err0), 32'(chk0), 32'(fexp0), 32'(fact0), 32'(fcyc0));
    check_inst(1, 32'(st1), 32'(pulse1), 32'(sticky1), 32'(err1), 32'(chk1), 32'(fexp1), 32'(fact1), 32'(fcyc1));
    check_inst(2, 32'(st2), 32'(pulse2), 32'(sticky2), 32'(err2), 32'(chk2), 32'(fexp2), 32'(fact2), 32'(fcyc2));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    for (int i = 0; i < 3; i++) dout[i] = W'(stage_out(i));
    for (int i = 0; i < 3; i++) model_step(i);
    for (int i = 0; i < 3; i++) begin
      if (dut_rst)     stage[i] = 0;
      else if (clk_en) stage[i] = int'(d);
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] saved;

  initial begin
    rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0; d = '0; dut_rst = 1'b0; clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m[i] = '{default: 0};
      stage[i] = 0; stale[i] = 1'b0; force_en[i] = 1'b0; force_val[i] = 0;
      dout[i] = '0;
    end
    #1;
    check_all();
    check("reset.state0", 32'(st0), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Registered stages wait for a model event; the bypass starts at once.
    chk_en = 1'b1;
    tick();
    check("a.wait0", 32'(st0), 32'(S_WAIT));
    check("a.run2", 32'(st2), 32'(S_RUN));
    dut_rst = 1'b1;
    tick();
    dut_rst = 1'b0; clk_en = 1'b1;
    for (int k = 0; k < 21; k++) begin
      d = W'($urandom);
      tick();
    end
    check("a.run0", 32'(st0), 32'(S_RUN));
    check("a.chk0", 32'(chk0), 32'd20);
    check("a.err0", 32'(err0), 32'd0);
    check("a.sticky0", 32'(sticky0), 32'd0);

    // First-failure capture on compare 5.
    clr = 1'b1; tick(); clr = 1'b0;
    check("b.clr_chk0", 32'(chk0), 32'd0);
    for (int k = 0; k < 3; k++) begin d = W'($urandom); tick(); end
    d = 18'h00ABC; tick();
    d = W'($urandom); force_en[0] = 1'b1; force_val[0] = 'h3FFFF; tick();
    check("b.pulse0", 32'(pulse0), 32'd1);
    check("b.err0", 32'(err0), 32'd1);
    check("b.fexp0", 32'(fexp0), 32'h00ABC);
    check("b.fact0", 32'(fact0), 32'h3FFFF);
    check("b.fcyc0", 32'(fcyc0), 32'd4);
    force_en[0] = 1'b0; d = W'($urandom); tick();
    check("b.pulse0_off", 32'(pulse0), 32'd0);

    // Async reset seen by a correct stage: no error.
    d = W'($urandom_range(1, 'h3FFFF)); tick();
    clk_en = 1'b0; dut_rst = 1'b1; tick();
    check("c.async_ok", 32'(err1), 32'd0);
    dut_rst = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    clk_en = 1'b1;
    d = W'($urandom_range(1, 'h3FFFF)); tick();
    d = W'($urandom_range(1, 'h3FFFF)); saved = d; tick();
    // Stale async stage on compare 3 halts the STOP_ON_ERR monitor.
    clk_en = 1'b0; dut_rst = 1'b1; stale[1] = 1'b1; tick();
    check("c.halt1", 32'(st1), 32'(S_HALT));
    check("c.err1", 32'(err1), 32'd1);
    check("c.fexp1", 32'(fexp1), 32'd0);
    check("c.fact1", 32'(fact1), 32'(saved));
    check("c.fcyc1", 32'(fcyc1), 32'd2);
    stale[1] = 1'b0; dut_rst = 1'b0; clk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin d = W'($urandom); tick(); end
    check("c.frozen1", 32'(chk1), 32'd3);
    clr = 1'b1; tick(); clr = 1'b0;
    check("c.resume1", 32'(st1), 32'(S_RUN));
    check("c.clr_chk1", 32'(chk1), 32'd0);
    check("c.clr_err1", 32'(err1), 32'd0);

    // Saturation of the 4-bit counters with continuous mismatches.
    force_en[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = W'($urandom);
      force_val[2] = int'(d ^ 18'h3FFFF);
      tick();
      check("d.pulse2", 32'(pulse2), 32'd1);
    end
    force_en[2] = 1'b0;
    check("d.err2_sat", 32'(err2), 32'd15);
    check("d.chk2_sat", 32'(chk2), 32'd15);

    // Randomized phase.
    for (int k = 0; k < 400; k++) begin
      d       = W'($urandom);
      clk_en  = ($urandom_range(0, 3) != 0);
      dut_rst = ($urandom_range(0, 15) == 0);
      chk_en  = ($urandom_range(0, 31) != 0);
      clr     = ($urandom_range(0, 31) == 0);
      stale[1] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        force_en[i]  = ($urandom_range(0, 19) == 0);
        force_val[i] = int'($urandom_range(0, 'h3FFFF));
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin force_en[i] = 1'b0; stale[i] = 1'b0; end
    chk_en = 1'b1; clr = 1'b0; dut_rst = 1'b0; clk_en = 1'b1;

    // Reset mid-RUN, then re-arm only after a fresh model event.
    tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      force_en[0] = 1'b1; force_val[0] = stage[0] ^ 'h3FFFF; tick();
    end
    force_en[0] = 1'b0;
    check("e.err0", 32'(err0), 32'd2);
    pulse_rst();
    check("e.rst_state0", 32'(st0), 32'(S_IDLE));
    check("e.rst_err0", 32'(err0), 32'd0);
    tick();
    check("e.wait0", 32'(st0), 32'(S_WAIT));
    check("e.run2", 32'(st2), 32'(S_RUN));
    tick();
    check("e.still_wait0", 32'(st0), 32'(S_WAIT));
    clk_en = 1'b1; d = W'($urandom); tick();
    check("e.wait_at_event0", 32'(st0), 32'(S_WAIT));
    clk_en = 1'b0; tick();
    check("e.rearmed0", 32'(st0), 32'(S_RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
